// File: rtl/id_ex_if.sv
// ID/EX stage bus: decode-side operands/controls in, EX-side registered copies out,
// plus the flush/hold controls and the hazard/stall-count status.
interface id_ex_if #(
  parameter int XLEN  = 64,
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [REG_W-1:0] id_rs1, id_rs2, id_rd;
  logic             id_uses_rs1, id_uses_rs2;
  logic             id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write, id_branch;
  logic [1:0]       id_alu_op;
  logic             flush, ex_hold;

  logic             hazard_stall;
  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [REG_W-1:0] ex_rs1, ex_rs2, ex_rd;
  logic             ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
  logic [1:0]       ex_alu_op;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_uses_rs1, id_uses_rs2, id_alu_src, id_mem_to_reg, id_reg_write,
           id_mem_read, id_mem_write, id_branch, id_alu_op, flush, ex_hold,
    input  hazard_stall, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_alu_src, ex_mem_to_reg, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_branch, ex_alu_op, stall_count
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_uses_rs1, id_uses_rs2, id_alu_src, id_mem_to_reg, id_reg_write,
           id_mem_read, id_mem_write, id_branch, id_alu_op, flush, ex_hold,
    output hazard_stall, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_alu_src, ex_mem_to_reg, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_branch, ex_alu_op, stall_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// branch flush, downstream hold and a saturating stall counter.
module id_ex_stage #(
  parameter int XLEN  = 64,
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input logic   clk,
  input logic   rst,
  id_ex_if.slave bus
);

  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  logic             valid_q, valid_d;
  ctrl_t            ctrl_q, ctrl_d, id_ctrl;
  logic [XLEN-1:0]  pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
  logic [REG_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             raw_hazard, stall;

  assign id_ctrl = '{alu_src:    bus.id_alu_src,
                     mem_to_reg: bus.id_mem_to_reg,
                     reg_write:  bus.id_reg_write,
                     mem_read:   bus.id_mem_read,
                     mem_write:  bus.id_mem_write,
                     branch:     bus.id_branch,
                     alu_op:     bus.id_alu_op};

  // x0 is never a real producer, so a load to x0 cannot create a hazard.
  assign raw_hazard = valid_q & ctrl_q.mem_read & (rd_q != '0) & bus.id_valid &
                      ((bus.id_uses_rs1 & (bus.id_rs1 == rd_q)) |
                       (bus.id_uses_rs2 & (bus.id_rs2 == rd_q)));
  assign stall = raw_hazard & ~bus.flush;

  always_comb begin
    valid_d    = valid_q;
    ctrl_d     = ctrl_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    cnt_d      = (stall && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

    // Flush and bubble only kill controls; datapath fields are don't-care when invalid.
    if (bus.flush || (!bus.ex_hold && stall)) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (!bus.ex_hold) begin
      valid_d    = bus.id_valid;
      ctrl_d     = bus.id_valid ? id_ctrl : '0;
      pc_d       = bus.id_pc;
      rs1_data_d = bus.id_rs1_data;
      rs2_data_d = bus.id_rs2_data;
      imm_d      = bus.id_imm;
      rs1_d      = bus.id_rs1;
      rs2_d      = bus.id_rs2;
      rd_d       = bus.id_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.hazard_stall  = stall;
  assign bus.ex_valid      = valid_q;
  assign bus.ex_pc         = pc_q;
  assign bus.ex_rs1_data   = rs1_data_q;
  assign bus.ex_rs2_data   = rs2_data_q;
  assign bus.ex_imm        = imm_q;
  assign bus.ex_rs1        = rs1_q;
  assign bus.ex_rs2        = rs2_q;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_alu_src    = ctrl_q.alu_src;
  assign bus.ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.ex_reg_write  = ctrl_q.reg_write;
  assign bus.ex_mem_read   = ctrl_q.mem_read;
  assign bus.ex_mem_write  = ctrl_q.mem_write;
  assign bus.ex_branch     = ctrl_q.branch;
  assign bus.ex_alu_op     = ctrl_q.alu_op;
  assign bus.stall_count   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load, load-use, false hazards, flush,
// invalid ID, hold and stall-counter saturation.
module tb_id_ex_stage;
  localparam int XLEN  = 64;
  localparam int REG_W = 5;
  localparam int CNT_W = 16;

  // control vector: {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op[1:0]}
  localparam logic [7:0] C_ADDI = 8'b1010_0000;
  localparam logic [7:0] C_ADD  = 8'b0010_0010;
  localparam logic [7:0] C_LD   = 8'b1111_0000;
  localparam logic [7:0] C_SD   = 8'b1000_1000;
  localparam logic [7:0] C_LUI  = 8'b1010_0011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  id_ex_if #(.XLEN(XLEN), .REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.XLEN(XLEN), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ex_ctrl();
    return {bus.ex_alu_src, bus.ex_mem_to_reg, bus.ex_reg_write, bus.ex_mem_read,
            bus.ex_mem_write, bus.ex_branch, bus.ex_alu_op};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [XLEN-1:0] pc,
                        input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                        input logic [REG_W-1:0] rd, input logic u1, input logic u2,
                        input logic [XLEN-1:0] imm, input logic [7:0] c);
    bus.id_valid      = v;
    bus.id_pc         = pc;
    bus.id_rs1        = rs1;
    bus.id_rs2        = rs2;
    bus.id_rd         = rd;
    bus.id_uses_rs1   = u1;
    bus.id_uses_rs2   = u2;
    bus.id_imm        = imm;
    bus.id_rs1_data   = pc ^ 64'hAAAA_0000_0000_1111;
    bus.id_rs2_data   = pc ^ 64'h5555_0000_0000_2222;
    {bus.id_alu_src, bus.id_mem_to_reg, bus.id_reg_write, bus.id_mem_read,
     bus.id_mem_write, bus.id_branch, bus.id_alu_op} = c;
    #1;
  endtask

  task automatic test_reset();
    // initial reset state
    nvec++;
    if (bus.ex_valid !== 1'b0 || ex_ctrl() !== 8'h00 || bus.stall_count !== '0 || bus.hazard_stall !== 1'b0) begin
      $display("FAIL reset_init valid=%0b ctrl=%02h cnt=%0h hz=%0b want 0", bus.ex_valid, ex_ctrl(), bus.stall_count, bus.hazard_stall);
      nerr++;
    end
    rst = 1'b0;
    set_id(1'b1, 64'h80, 5'd1, 5'd0, 5'd9, 1'b1, 1'b0, 64'd7, C_ADDI);
    step();
    nvec++;
    if (bus.ex_valid !== 1'b1 || bus.ex_reg_write !== 1'b1) begin
      $display("FAIL reset_preload valid=%0b rw=%0b want 1 1", bus.ex_valid, bus.ex_reg_write);
      nerr++;
    end
    // assert mid-cycle; outputs must clear without waiting for clk
    #3 rst = 1'b1;
    #1;
    nvec++;
    if (bus.ex_valid !== 1'b0 || ex_ctrl() !== 8'h00 || bus.ex_pc !== '0 || bus.ex_rd !== '0 ||
        bus.ex_imm !== '0 || bus.stall_count !== '0 || bus.hazard_stall !== 1'b0) begin
      $display("FAIL reset_async valid=%0b ctrl=%02h pc=%0h rd=%0d imm=%0h cnt=%0h want all 0",
               bus.ex_valid, ex_ctrl(), bus.ex_pc, bus.ex_rd, bus.ex_imm, bus.stall_count);
      nerr++;
    end
    #1 rst = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic test_normal_load();
    set_id(1'b1, 64'h40, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 64'd3, C_ADDI);
    step();
    nvec++;
    if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd5 || bus.ex_imm !== 64'd3 || bus.ex_pc !== 64'h40 ||
        bus.ex_rs1 !== 5'd1 || ex_ctrl() !== C_ADDI || bus.hazard_stall !== 1'b0) begin
      $display("FAIL normal_load valid=%0b rd=%0d imm=%0h pc=%0h rs1=%0d ctrl=%02h hz=%0b want 1 5 3 40 1 %02h 0",
               bus.ex_valid, bus.ex_rd, bus.ex_imm, bus.ex_pc, bus.ex_rs1, ex_ctrl(), bus.hazard_stall, C_ADDI);
      nerr++;
    end
    nvec++;
    if (bus.ex_rs1_data !== (64'h40 ^ 64'hAAAA_0000_0000_1111)) begin
      $display("FAIL normal_rs1_data got %0h want %0h", bus.ex_rs1_data, 64'h40 ^ 64'hAAAA_0000_0000_1111);
      nerr++;
    end
  endtask

  task automatic test_load_use();
    set_id(1'b1, 64'h44, 5'd2, 5'd0, 5'd6, 1'b1, 1'b0, 64'd8, C_LD);
    step();
    set_id(1'b1, 64'h48, 5'd6, 5'd2, 5'd7, 1'b1, 1'b1, 64'd0, C_ADD);
    nvec++;
    if (bus.hazard_stall !== 1'b1) begin
      $display("FAIL loaduse_detect hz=%0b want 1", bus.hazard_stall);
      nerr++;
    end
    step();
    exp_cnt++;
    nvec++;
    if (bus.ex_valid !== 1'b0 || ex_ctrl() !== 8'h00 || bus.stall_count !== exp_cnt ||
        bus.ex_rd !== 5'd6 || bus.hazard_stall !== 1'b0) begin
      $display("FAIL loaduse_bubble valid=%0b ctrl=%02h cnt=%0d rd=%0d hz=%0b want 0 00 %0d 6 0",
               bus.ex_valid, ex_ctrl(), bus.stall_count, bus.ex_rd, bus.hazard_stall, exp_cnt);
      nerr++;
    end
    step();
    nvec++;
    if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd7 || ex_ctrl() !== C_ADD || bus.ex_pc !== 64'h48 ||
        bus.hazard_stall !== 1'b0 || bus.stall_count !== exp_cnt) begin
      $display("FAIL loaduse_resume valid=%0b rd=%0d ctrl=%02h pc=%0h hz=%0b cnt=%0d want 1 7 %02h 48 0 %0d",
               bus.ex_valid, bus.ex_rd, ex_ctrl(), bus.ex_pc, bus.hazard_stall, bus.stall_count, C_ADD, exp_cnt);
      nerr++;
    end
  endtask

  task automatic test_no_false_hazard();
    set_id(1'b1, 64'h50, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 64'd0, C_LD);
    step();
    set_id(1'b1, 64'h54, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 64'd0, C_ADD);
    nvec++;
    if (bus.hazard_stall !== 1'b0) begin
      $display("FAIL nohz_x0 hz=%0b want 0", bus.hazard_stall);
      nerr++;
    end
    set_id(1'b1, 64'h58, 5'd2, 5'd0, 5'd6, 1'b1, 1'b0, 64'd0, C_LD);
    step();
    set_id(1'b1, 64'h5C, 5'd6, 5'd6, 5'd6, 1'b0, 1'b0, 64'h1000, C_LUI);
    nvec++;
    if (bus.hazard_stall !== 1'b0) begin
      $display("FAIL nohz_lui hz=%0b want 0", bus.hazard_stall);
      nerr++;
    end
    // store data operand is rs2 and must stall
    set_id(1'b1, 64'h5C, 5'd1, 5'd6, 5'd0, 1'b1, 1'b1, 64'd16, C_SD);
    nvec++;
    if (bus.hazard_stall !== 1'b1) begin
      $display("FAIL store_rs2_hz hz=%0b want 1", bus.hazard_stall);
      nerr++;
    end
  endtask

  task automatic test_flush();
    // EX still holds ld x6, ID holds sd using x6
    bus.flush = 1'b1;
    #1;
    nvec++;
    if (bus.hazard_stall !== 1'b0) begin
      $display("FAIL flush_masks_hz hz=%0b want 0", bus.hazard_stall);
      nerr++;
    end
    step();
    bus.flush = 1'b0;
    #1;
    nvec++;
    if (bus.ex_valid !== 1'b0 || ex_ctrl() !== 8'h00 || bus.stall_count !== exp_cnt || bus.ex_rd !== 5'd6) begin
      $display("FAIL flush_result valid=%0b ctrl=%02h cnt=%0d rd=%0d want 0 00 %0d 6",
               bus.ex_valid, ex_ctrl(), bus.stall_count, bus.ex_rd, exp_cnt);
      nerr++;
    end
  endtask

  task automatic test_invalid_id();
    set_id(1'b0, 64'h60, 5'd3, 5'd4, 5'd8, 1'b1, 1'b1, 64'd5, C_LD);
    step();
    nvec++;
    if (bus.ex_valid !== 1'b0 || ex_ctrl() !== 8'h00 || bus.ex_pc !== 64'h60 || bus.ex_rd !== 5'd8) begin
      $display("FAIL invalid_id valid=%0b ctrl=%02h pc=%0h rd=%0d want 0 00 60 8",
               bus.ex_valid, ex_ctrl(), bus.ex_pc, bus.ex_rd);
      nerr++;
    end
  endtask

  task automatic test_hold();
    set_id(1'b1, 64'h70, 5'd2, 5'd0, 5'd6, 1'b1, 1'b0, 64'd24, C_LD);
    step();
    set_id(1'b1, 64'h74, 5'd6, 5'd2, 5'd7, 1'b1, 1'b1, 64'd0, C_ADD);
    bus.ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_cnt++;
    end
    nvec++;
    if (bus.ex_valid !== 1'b1 || ex_ctrl() !== C_LD || bus.ex_rd !== 5'd6 || bus.ex_pc !== 64'h70 ||
        bus.hazard_stall !== 1'b1 || bus.stall_count !== exp_cnt) begin
      $display("FAIL hold_3 valid=%0b ctrl=%02h rd=%0d pc=%0h hz=%0b cnt=%0d want 1 %02h 6 70 1 %0d",
               bus.ex_valid, ex_ctrl(), bus.ex_rd, bus.ex_pc, bus.hazard_stall, bus.stall_count, C_LD, exp_cnt);
      nerr++;
    end
    bus.ex_hold = 1'b0;
    step();
    exp_cnt++;
    nvec++;
    if (bus.ex_valid !== 1'b0 || ex_ctrl() !== 8'h00 || bus.stall_count !== exp_cnt) begin
      $display("FAIL hold_release valid=%0b ctrl=%02h cnt=%0d want 0 00 %0d",
               bus.ex_valid, ex_ctrl(), bus.stall_count, exp_cnt);
      nerr++;
    end
  endtask

  task automatic test_saturation();
    set_id(1'b1, 64'h80, 5'd2, 5'd0, 5'd6, 1'b1, 1'b0, 64'd0, C_LD);
    step();
    set_id(1'b1, 64'h84, 5'd6, 5'd0, 5'd9, 1'b1, 1'b0, 64'd0, C_ADD);
    bus.ex_hold = 1'b1;
    for (int i = 0; i < 65540; i++) @(posedge clk);
    #1;
    nvec++;
    if (bus.stall_count !== 16'hFFFF || bus.ex_valid !== 1'b1 || bus.hazard_stall !== 1'b1) begin
      $display("FAIL sat_reach cnt=%0h valid=%0b hz=%0b want ffff 1 1", bus.stall_count, bus.ex_valid, bus.hazard_stall);
      nerr++;
    end
    for (int i = 0; i < 4; i++) step();
    nvec++;
    if (bus.stall_count !== 16'hFFFF) begin
      $display("FAIL sat_hold cnt=%0h want ffff", bus.stall_count);
      nerr++;
    end
    bus.ex_hold = 1'b0;
  endtask

  initial begin
    bus.flush   = 1'b0;
    bus.ex_hold = 1'b0;
    set_id(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0, 8'h00);
    test_reset();
    test_normal_load();
    test_load_use();
    test_no_false_hazard();
    test_flush();
    test_invalid_id();
    test_hold();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register for the 64-bit RISC-V pipeline. It sits between decode (consumer of IF/ID output, register bank, control unit, immgen) and the execute stage (ALU, branch adder, data memory path). It registers decoded control and operands and detects load-use hazards against the instruction currently in EX. On a hazard it inserts a bubble and tells IF/ID and the PC to hold. It also supports branch flush and an external hold, and keeps a saturating stall counter.

Parameters:
XLEN, 64, datapath width (PC, register data, immediate)
REG_W, 5, register index width
CNT_W, 16, stall counter width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
id_valid  input  1  ID holds a real instruction
id_pc  input  XLEN  PC of ID instruction
id_rs1_data  input  XLEN  register bank read port 1
id_rs2_data  input  XLEN  register bank read port 2
id_imm  input  XLEN  sign-extended immediate
id_rs1  input  REG_W  source index 1
id_rs2  input  REG_W  source index 2
id_rd  input  REG_W  destination index
id_uses_rs1  input  1  instruction reads rs1
id_uses_rs2  input  1  instruction reads rs2
id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write, id_branch  input  1 each  control unit outputs
id_alu_op  input  2  ALU operation select
flush  input  1  branch taken in EX; kill ID instruction
ex_hold  input  1  downstream stall; freeze EX registers
hazard_stall  output  1  hold PC and IF/ID this cycle (combinational)
ex_valid  output  1  EX holds a real instruction
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  output  XLEN each  registered ID values
ex_rs1, ex_rs2, ex_rd  output  REG_W each  registered indices
ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  output  1 each  registered control
ex_alu_op  output  2  registered ALU op
stall_count  output  CNT_W  number of load-use stall cycles

Behaviour:
- Reset (async, immediate, mid-operation included): all ex_* outputs 0, ex_valid=0, stall_count=0. hazard_stall is 0 while ex_valid=0.
- raw_hazard = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- hazard_stall = raw_hazard & ~flush. It is purely combinational from current EX registers and ID inputs.
- Update priority at each rising clk edge:
  1. flush: ex_valid<=0 and all six 1-bit controls plus ex_alu_op <=0. Datapath and index fields hold.
  2. ex_hold (no flush): every EX register holds.
  3. hazard_stall: insert a bubble. Controls and ex_valid are zeroed; datapath and index fields hold.
  4. Otherwise: load all ID fields. ex_valid<=id_valid. If id_valid=0, controls load as 0.
- Latency: 1 cycle, ID to EX.
- Stall length: a load-use stall lasts exactly 1 cycle when ex_hold=0, because the bubble clears ex_mem_read. With ex_hold=1 the load stays in EX, and hazard_stall stays asserted for as long as the hold lasts.
- Register x0: ex_rd=0 never causes a hazard.
- Stores: a store uses rs2 and causes a hazard like any other reader.
- stall_count: increments on each clock edge where hazard_stall=1. It saturates at 2^CNT_W-1 and does not wrap. Only rst clears it.
- Invalid-EX guarantee: controls are 0 whenever ex_valid=0. No reg_write or mem_write leaks from a bubble or flush.

Test Plan:
- Reset: assert rst mid-cycle with EX loaded (ex_reg_write=1, ex_valid=1) -> all outputs 0 immediately, before the next clk edge.
- Normal load: ID addi x5,x1,3 (id_rs1=1, id_imm=3, reg_write=1, pc=0x40) -> next edge ex_valid=1, ex_rd=5, ex_imm=3, ex_pc=0x40, hazard_stall=0.
- Load-use: EX ld x6 (mem_read=1, rd=6); ID add x7,x6,x2 -> hazard_stall=1. Next edge ex_valid=0 with all controls 0, stall_count=1. Following edge with the same ID loads add; hazard_stall=0.
- No false hazard: EX ld x0 and ID uses rs1=0 -> hazard_stall=0. EX ld x6 and ID lui x6 (uses_rs1=0, uses_rs2=0) -> hazard_stall=0.
- Flush over hazard: load-use condition with flush=1 -> hazard_stall=0, next edge ex_valid=0, stall_count unchanged.
- Hold and saturation: ex_hold=1 for 3 edges during load-use -> EX unchanged, stall_count +3. With stall_count preloaded to 0xFFFF by a long hold, it stays 0xFFFF.
